// File: rtl/image_stream_source.sv
// Streams a locally buffered ImageWidth x ImageWidth image in raster order over valid/ready,
// spacing transfers CyclesPerPixel cycles apart and pulsing out_done after the last pixel.
module image_stream_source #(
  parameter int BitSize        = 32,
  parameter int ImageWidth     = 8,
  parameter int CyclesPerPixel = 2,
  localparam int AddrBits      = $clog2(ImageWidth * ImageWidth)
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                in_wr_en,
  input  logic [AddrBits-1:0] in_wr_addr,
  input  logic [BitSize-1:0]  in_wr_data,
  input  logic                in_start,
  input  logic                in_ready,
  output logic                out_valid,
  output logic [BitSize-1:0]  out_data,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_wr_overrun
);

  localparam int NumPixels = ImageWidth * ImageWidth;
  localparam int GapBits   = (CyclesPerPixel > 2) ? $clog2(CyclesPerPixel - 1) : 1;
  localparam logic [GapBits-1:0]  GapInit = GapBits'((CyclesPerPixel > 1) ? CyclesPerPixel - 2 : 0);
  localparam logic [AddrBits-1:0] LastIdx = AddrBits'(NumPixels - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t               state_q;
  logic [AddrBits-1:0]  pix_idx_q;
  logic [AddrBits-1:0]  pix_idx_d;
  logic [GapBits-1:0]   gap_cnt_q;
  logic                 valid_q;
  logic [BitSize-1:0]   data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overrun_q;
  logic [BitSize-1:0]   buf_q [NumPixels];

  assign pix_idx_d = pix_idx_q + AddrBits'(1);

  // Buffer is deliberately left out of reset so a loaded image survives it.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_wr_en && !in_start) begin
      buf_q[in_wr_addr] <= in_wr_data;
    end
  end

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state_q   <= IDLE;
      pix_idx_q <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_start) begin
            pix_idx_q <= '0;
            data_q    <= buf_q[0];
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            overrun_q <= in_wr_en;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (in_ready) begin
            if (pix_idx_q == LastIdx) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (CyclesPerPixel == 1) begin
              pix_idx_q <= pix_idx_d;
              data_q    <= buf_q[pix_idx_d];
            end else begin
              valid_q   <= 1'b0;
              gap_cnt_q <= GapInit;
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            pix_idx_q <= pix_idx_d;
            data_q    <= buf_q[pix_idx_d];
            valid_q   <= 1'b1;
            state_q   <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - GapBits'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (in_wr_en && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_busy       = busy_q;
  assign out_done       = done_q;
  assign out_wr_overrun = overrun_q;

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: an 8x8 / 2-cycle instance driven with directed and random
// streams, plus a 4x4 / 1-cycle instance for back-to-back transfer.
module tb_image_stream_source;
  localparam int BW  = 32;
  localparam int IW  = 8;
  localparam int CPP = 2;
  localparam int N   = IW * IW;

  logic          clk = 1'b0;
  logic          res_n;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [BW-1:0] wr_data;
  logic          start, ready;
  logic          valid, busy, done, ovr;
  logic [BW-1:0] data;

  logic          s_wr_en;
  logic [3:0]    s_wr_addr;
  logic [BW-1:0] s_wr_data;
  logic          s_start, s_ready;
  logic          s_valid, s_busy, s_done, s_ovr;
  logic [BW-1:0] s_data;

  int            vectors = 0;
  int            miscompares = 0;
  logic [BW-1:0] mem [N];
  logic          exp_ovr;
  int            dcyc;

  always #5 clk = ~clk;

  image_stream_source #(.BitSize(BW), .ImageWidth(IW), .CyclesPerPixel(CPP)) u_dut (
    .clk(clk), .res_n(res_n), .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
    .in_start(start), .in_ready(ready), .out_valid(valid), .out_data(data), .out_busy(busy),
    .out_done(done), .out_wr_overrun(ovr));

  image_stream_source #(.BitSize(BW), .ImageWidth(4), .CyclesPerPixel(1)) u_dut1 (
    .clk(clk), .res_n(res_n), .in_wr_en(s_wr_en), .in_wr_addr(s_wr_addr), .in_wr_data(s_wr_data),
    .in_start(s_start), .in_ready(s_ready), .out_valid(s_valid), .out_data(s_data), .out_busy(s_busy),
    .out_done(s_done), .out_wr_overrun(s_ovr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_px(input int a, input logic [BW-1:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    mem[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  // Reference: pixel k is offered once CPP cycles have passed since pixel k-1 transferred,
  // stays offered until ready, and done follows the last transfer by one cycle.
  task automatic run_stream(input bit rnd_ready, input int stall_pix, input int stall_len,
                            input int abort_pix, input bit pulse_start, input int mid_wr_pix,
                            input bit start_wr, output int done_cyc);
    int k, next_ok, done_at, stalled;
    bit ev, rdy;
    k = 0; next_ok = 1; done_at = -1; stalled = 0; done_cyc = -1;
    start = 1'b1; ready = 1'b1;
    if (start_wr) begin
      wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hBEEF;
    end
    exp_ovr = start_wr;
    step();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      ev = (k < N) && (c >= next_ok);
      chk("valid", valid, ev);
      if (ev) chk($sformatf("data[%0d]", k), data, mem[k]);
      chk("done", done, c == done_at);
      chk("busy", busy, 1'b1);
      chk("overrun", ovr, exp_ovr);
      if (c == done_at) begin
        done_cyc = c;
        start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        start = 1'b0;
        break;
      end
      if (abort_pix >= 0 && ev && k == abort_pix) begin
        res_n = 1'b1;
        #1;
        chk("abort_valid", valid, 1'b0);
        chk("abort_data", data, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        step();
        res_n = 1'b0;
        for (int j = 0; j < 4; j++) begin
          step();
          chk("post_abort_done", done, 1'b0);
          chk("post_abort_busy", busy, 1'b0);
          chk("post_abort_valid", valid, 1'b0);
        end
        done_cyc = -2;
        return;
      end
      rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ev && k == stall_pix && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      ready = rdy;
      start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ev && k == mid_wr_pix) begin
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEAD;
        exp_ovr = 1'b1;
      end
      if (ev && rdy) begin
        k++;
        next_ok = c + CPP;
        if (k == N) done_at = c + 1;
      end
      step();
      wr_en = 1'b0;
    end
    chk("stream_terminated", 32'(done_cyc >= 0), 32'd1);
    chk("idle_valid", valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  initial begin
    res_n = 1'b1;
    wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; ready = 0;
    s_wr_en = 0; s_wr_addr = '0; s_wr_data = '0; s_start = 0; s_ready = 0;
    step(); step();
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", ovr, 1'b0);
    chk("rst1_valid", s_valid, 1'b0);
    res_n = 1'b0;
    step();

    // Incrementing image, ready held high, then a 5-cycle stall at pixel 10.
    for (int i = 0; i < N; i++) write_px(i, BW'(i + 100));
    run_stream(0, -1, 0, -1, 0, -1, 0, dcyc);
    chk("done_cycle_free", dcyc, 2 + (N - 1) * CPP);
    step();
    run_stream(0, 10, 5, -1, 0, -1, 0, dcyc);
    chk("done_cycle_stall", dcyc, 2 + (N - 1) * CPP + 5);

    // Random image; pixel 0 rewritten the cycle before start; random ready and start pulses.
    for (int i = 0; i < N; i++) write_px(i, $urandom);
    write_px(0, $urandom);
    run_stream(1, -1, 0, -1, 1, -1, 0, dcyc);
    run_stream(0, -1, 0, -1, 1, -1, 0, dcyc);
    chk("done_cycle_pulsed", dcyc, 2 + (N - 1) * CPP);

    // Write overrun: drop during SEND, drop coincident with start, clear on clean start.
    run_stream(1, -1, 0, -1, 0, 7, 0, dcyc);
    step();
    chk("overrun_sticky_idle", ovr, 1'b1);
    run_stream(0, -1, 0, -1, 0, -1, 1, dcyc);
    chk("overrun_after_wr_start", ovr, 1'b1);
    run_stream(0, -1, 0, -1, 0, -1, 0, dcyc);
    chk("overrun_cleared", ovr, 1'b0);

    // Reset mid-stream at pixel 20, then the retained buffer streams again.
    run_stream(0, -1, 0, 20, 0, -1, 0, dcyc);
    run_stream(1, -1, 0, -1, 0, -1, 0, dcyc);

    // Single-cycle spacing on the 4x4 instance.
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 4'(i); s_wr_data = BW'(i);
      step();
    end
    s_wr_en = 1'b0; s_start = 1'b1; s_ready = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      chk("b2b_valid", s_valid, c <= 16);
      if (c <= 16) chk("b2b_data", s_data, BW'(c - 1));
      chk("b2b_done", s_done, c == 17);
      chk("b2b_busy", s_busy, 1'b1);
      step();
    end
    chk("b2b_idle_busy", s_busy, 1'b0);
    chk("b2b_idle_done", s_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
